// File: rtl/palette_loader_if.sv
// Host command stream, colour word streams and palette controller port
// bundled into one interface. The loader uses the slave view; the host and
// palette side uses the master view.
interface palette_loader_if;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdRead;
  logic [4:0]  cmdLayer;
  logic [4:0]  cmdStartColor;
  logic [4:0]  cmdCount;
  logic        wrDataValid;
  logic        wrDataReady;
  logic [47:0] wrData;
  logic        rdDataValid;
  logic        rdDataReady;
  logic [47:0] rdData;
  logic        palWriteEn;
  logic [4:0]  palLayer;
  logic [4:0]  palColor;
  logic [1:0]  palRGB;
  logic [15:0] palWriteData;
  logic [15:0] palReadData;
  logic        busy;
  logic        done;

  modport slave (
    input  cmdValid, cmdRead, cmdLayer, cmdStartColor, cmdCount,
    input  wrDataValid, wrData, rdDataReady, palReadData,
    output cmdReady, wrDataReady, rdDataValid, rdData,
    output palWriteEn, palLayer, palColor, palRGB, palWriteData, busy, done
  );

  modport master (
    output cmdValid, cmdRead, cmdLayer, cmdStartColor, cmdCount,
    output wrDataValid, wrData, rdDataReady, palReadData,
    input  cmdReady, wrDataReady, rdDataValid, rdData,
    input  palWriteEn, palLayer, palColor, palRGB, palWriteData, busy, done
  );
endinterface

// File: rtl/palette_loader.sv
// Palette loader: turns host load/readback commands into per-channel
// palette writes (R, G, B from one 48-bit word) and assembles per-channel
// palette reads back into 48-bit words. Colour 0 is never addressed.
module palette_loader #(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  palette_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WR_R, S_WR_G, S_WR_B, S_RD_CH, S_RD_OUT
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT);

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_layer;
  logic [4:0]  r_index;
  logic [4:0]  r_remaining;
  logic [47:0] r_wr_word;
  logic [47:0] r_rd_data;
  logic [1:0]  r_ch;
  logic [2:0]  r_lat_cnt;
  logic        r_done;

  logic        w_cmd_fire;
  logic        w_wr_fire;
  logic        w_rd_fire;
  logic        w_last;
  logic        w_lat_done;
  logic [4:0]  w_next_index;

  assign w_cmd_fire   = bus.cmdValid && (r_state == S_IDLE);
  assign w_wr_fire    = bus.wrDataValid && (r_state == S_FETCH);
  assign w_rd_fire    = bus.rdDataReady && (r_state == S_RD_OUT);
  assign w_last       = (r_remaining == 5'd1);
  assign w_lat_done   = (r_lat_cnt == LAT_LAST);
  // Index wraps 31 -> 1 so colour 0 is skipped entirely.
  assign w_next_index = (r_index == 5'd31) ? 5'd1 : r_index + 5'd1;

  assign bus.palLayer = r_layer;
  assign bus.palColor = r_index;
  assign bus.rdData   = r_rd_data;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_cmd_fire && (bus.cmdCount != 5'd0))
                  w_state_next = bus.cmdRead ? S_RD_CH : S_FETCH;
      S_FETCH:  if (w_wr_fire) w_state_next = S_WR_R;
      S_WR_R:   w_state_next = S_WR_G;
      S_WR_G:   w_state_next = S_WR_B;
      S_WR_B:   w_state_next = w_last ? S_IDLE : S_FETCH;
      S_RD_CH:  if (w_lat_done && (r_ch == 2'd2)) w_state_next = S_RD_OUT;
      S_RD_OUT: if (w_rd_fire) w_state_next = w_last ? S_IDLE : S_RD_CH;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Per-state outputs; cmdReady is held low while reset is asserted.
  always_comb begin
    bus.cmdReady     = 1'b0;
    bus.wrDataReady  = 1'b0;
    bus.rdDataValid  = 1'b0;
    bus.palWriteEn   = 1'b0;
    bus.palRGB       = 2'b11;
    bus.palWriteData = 16'd0;
    case (r_state)
      S_IDLE:   bus.cmdReady = rst;
      S_FETCH:  bus.wrDataReady = 1'b1;
      S_WR_R: begin
        bus.palWriteEn   = 1'b1;
        bus.palRGB       = 2'b00;
        bus.palWriteData = r_wr_word[47:32];
      end
      S_WR_G: begin
        bus.palWriteEn   = 1'b1;
        bus.palRGB       = 2'b01;
        bus.palWriteData = r_wr_word[31:16];
      end
      S_WR_B: begin
        bus.palWriteEn   = 1'b1;
        bus.palRGB       = 2'b10;
        bus.palWriteData = r_wr_word[15:0];
      end
      S_RD_CH:  bus.palRGB = r_ch;
      S_RD_OUT: bus.rdDataValid = 1'b1;
      default:  ;
    endcase
  end

  // Command latch, index/count bookkeeping, read assembly and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_layer     <= 5'd0;
      r_index     <= 5'd0;
      r_remaining <= 5'd0;
      r_wr_word   <= 48'd0;
      r_rd_data   <= 48'd0;
      r_ch        <= 2'd0;
      r_lat_cnt   <= 3'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_cmd_fire) begin
          r_layer     <= bus.cmdLayer;
          r_index     <= (bus.cmdStartColor == 5'd0) ? 5'd1 : bus.cmdStartColor;
          r_remaining <= bus.cmdCount;
          r_ch        <= 2'd0;
          r_lat_cnt   <= 3'd0;
          if (bus.cmdCount == 5'd0) r_done <= 1'b1;
        end
        S_FETCH: if (w_wr_fire) r_wr_word <= bus.wrData;
        S_WR_B: begin
          r_remaining <= r_remaining - 5'd1;
          r_index     <= w_next_index;
          if (w_last) r_done <= 1'b1;
        end
        S_RD_CH: begin
          if (w_lat_done) begin
            r_lat_cnt <= 3'd0;
            case (r_ch)
              2'd0:    r_rd_data[47:32] <= bus.palReadData;
              2'd1:    r_rd_data[31:16] <= bus.palReadData;
              default: r_rd_data[15:0]  <= bus.palReadData;
            endcase
            r_ch <= (r_ch == 2'd2) ? 2'd0 : r_ch + 2'd1;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_RD_OUT: if (w_rd_fire) begin
          r_remaining <= r_remaining - 5'd1;
          r_index     <= w_next_index;
          if (w_last) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_palette_loader.sv
// Bench for palette_loader: backing palette RAM with RD_LAT latency, a
// colour-word feeder, a readback acceptor, table-driven commands checked
// against a list-based reference model, hand sequences and random commands.
module tb_palette_loader;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  palette_loader_if bus();
  palette_loader #(.RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Palette RAM as seen by the DUT, and the bench's own expected copy.
  logic [15:0] pal_mem [32][32][4];
  logic [15:0] ref_pal [32][32][4];
  logic [15:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= pal_mem[bus.palLayer][bus.palColor][bus.palRGB];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.palReadData = rd_pipe[RD_LAT-1];

  // Write monitor: {layer, colour, channel, data} plus cycle stamp.
  logic [27:0] wr_log[$];
  int          wr_cyc[$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (bus.palWriteEn) begin
      wr_log.push_back({bus.palLayer, bus.palColor, bus.palRGB, bus.palWriteData});
      wr_cyc.push_back(cyc);
      pal_mem[bus.palLayer][bus.palColor][bus.palRGB] = bus.palWriteData;
    end
    if (bus.done) done_cnt++;
  end

  // Colour-word feeder: mode 0 always valid, 1 = 1-0-0-1 pattern, 2 random.
  logic [47:0] feed_q[$];
  int          feed_mode = 0;
  int          feed_ph   = 0;
  initial begin
    bus.wrDataValid = 1'b0;
    bus.wrData      = '0;
    forever begin
      bit v;
      @(negedge clk);
      case (feed_mode)
        0:       v = 1'b1;
        1:       v = ((feed_ph % 4) == 0) || ((feed_ph % 4) == 3);
        default: v = ($urandom % 2) == 0;
      endcase
      feed_ph++;
      v = v && (feed_q.size() > 0) && (rst == 1'b1);
      bus.wrDataValid = v;
      bus.wrData      = (feed_q.size() > 0) ? feed_q[0] : 48'd0;
      if (v && bus.wrDataReady) void'(feed_q.pop_front());
    end
  end

  // Readback acceptor: mode 0 always ready, 1 random, 2 left to the test.
  logic [47:0] rd_log[$];
  int          rd_mode = 0;
  logic [47:0] held;
  bit          holding = 0;
  initial begin
    bus.rdDataReady = 1'b1;
    forever begin
      @(negedge clk);
      if (rd_mode != 2) begin
        bus.rdDataReady = (rd_mode == 0) ? 1'b1 : (($urandom % 3) == 0);
        if (bus.rdDataValid && bus.rdDataReady) begin
          rd_log.push_back(bus.rdData);
          holding = 0;
        end else if (bus.rdDataValid) begin
          if (holding) check("rd_hold", 64'(bus.rdData), 64'(held));
          held    = bus.rdData;
          holding = 1;
        end else begin
          holding = 0;
        end
      end
    end
  end

  logic [47:0] preset[$];

  task automatic send_cmd(input bit rd, input logic [4:0] layer, input logic [4:0] start,
                          input logic [4:0] count);
    bit ok = 0;
    @(negedge clk);
    bus.cmdValid      = 1'b1;
    bus.cmdRead       = rd;
    bus.cmdLayer      = layer;
    bus.cmdStartColor = start;
    bus.cmdCount      = count;
    for (int n = 0; n < 100; n++) begin
      if (bus.cmdReady) begin ok = 1; break; end
      @(negedge clk);
    end
    check("cmd_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.cmdValid = 1'b0;
  endtask

  task automatic run_cmd(input bit rd, input logic [4:0] layer, input logic [4:0] start,
                         input logic [4:0] count, input int fmode, input int rmode,
                         output int nwr, output int nrd,
                         output logic [4:0] first_c, output logic [4:0] last_c);
    logic [27:0] exp_wr[$];
    logic [47:0] exp_rd[$];
    logic [47:0] w;
    logic [15:0] s;
    int idx, base;
    bit seen;
    idx = (start == 5'd0) ? 1 : int'(start);
    for (int i = 0; i < int'(count); i++) begin
      if (rd) begin
        exp_rd.push_back({ref_pal[layer][idx][0], ref_pal[layer][idx][1], ref_pal[layer][idx][2]});
      end else begin
        if (preset.size() > 0) w = preset.pop_front();
        else w = {16'($urandom), 16'($urandom), 16'($urandom)};
        feed_q.push_back(w);
        for (int c = 0; c < 3; c++) begin
          s = (c == 0) ? w[47:32] : (c == 1) ? w[31:16] : w[15:0];
          exp_wr.push_back({layer, 5'(idx), 2'(c), s});
          ref_pal[layer][idx][c] = s;
        end
      end
      idx = (idx == 31) ? 1 : idx + 1;
    end
    wr_log.delete(); wr_cyc.delete(); rd_log.delete();
    feed_mode = fmode; rd_mode = rmode; base = done_cnt;
    send_cmd(rd, layer, start, count);
    if (count == 5'd0) begin
      @(negedge clk);
      check("noop_done", 64'(bus.done), 64'd1);
    end else begin
      seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
        @(negedge clk);
        if (bus.done) seen = 1;
        else check("cmd_ready_while_busy", 64'(bus.cmdReady), 64'd0);
      end
      check("done_seen", 64'(seen), 64'd1);
    end
    @(negedge clk);
    check("done_count", 64'(done_cnt - base), 64'd1);
    check("n_writes", 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check("wr_entry", 64'(wr_log[i]), 64'(exp_wr[i]));
    if (fmode == 0)
      for (int i = 1; i < wr_cyc.size(); i++)
        check("wr_spacing", 64'(wr_cyc[i] - wr_cyc[i-1]), ((i % 3) == 0) ? 64'd2 : 64'd1);
    check("n_reads", 64'(rd_log.size()), 64'(exp_rd.size()));
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      check("rd_word", 64'(rd_log[i]), 64'(exp_rd[i]));
    nwr = wr_log.size();
    nrd = rd_log.size();
    first_c = (nwr > 0) ? wr_log[0][22:18] : 5'd0;
    last_c  = (nwr > 0) ? wr_log[nwr-1][22:18] : 5'd0;
  endtask

  typedef struct {
    bit         rd;
    logic [4:0] layer, start, count;
    int         fmode, rmode;
    int         exp_nwr, exp_nrd;
    logic [4:0] exp_first, exp_last;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int nwr, nrd, k;
    logic [4:0] fc, lc;
    logic [47:0] w1, w2, hv;
    int base;
    bit found;

    for (int l = 0; l < 32; l++)
      for (int c = 0; c < 32; c++)
        for (int ch = 0; ch < 4; ch++) begin
          pal_mem[l][c][ch] = (ch == 3) ? 16'd0 : 16'($urandom);
          ref_pal[l][c][ch] = pal_mem[l][c][ch];
        end
    bus.cmdValid = 1'b0; bus.cmdRead = 1'b0; bus.cmdLayer = '0;
    bus.cmdStartColor = '0; bus.cmdCount = '0;

    //            rd layer start cnt fm rm nwr nrd first last
    vecs[0] = '{1'b0, 5'd3,  5'd5,  5'd2, 0, 0, 6, 0, 5'd5,  5'd6};
    vecs[1] = '{1'b0, 5'd10, 5'd30, 5'd3, 0, 0, 9, 0, 5'd30, 5'd1};
    vecs[2] = '{1'b0, 5'd11, 5'd0,  5'd1, 0, 0, 3, 0, 5'd1,  5'd1};
    vecs[3] = '{1'b0, 5'd3,  5'd12, 5'd2, 1, 0, 6, 0, 5'd12, 5'd13};
    vecs[4] = '{1'b1, 5'd3,  5'd5,  5'd2, 0, 1, 0, 2, 5'd0,  5'd0};
    vecs[5] = '{1'b1, 5'd10, 5'd31, 5'd2, 0, 0, 0, 2, 5'd0,  5'd0};
    vecs[6] = '{1'b0, 5'd12, 5'd7,  5'd0, 0, 0, 0, 0, 5'd0,  5'd0};

    // Reset values while rst is held low.
    repeat (3) @(negedge clk);
    check("rst_palWriteEn", 64'(bus.palWriteEn), 64'd0);
    check("rst_palRGB", 64'(bus.palRGB), 64'd3);
    check("rst_palLayer", 64'(bus.palLayer), 64'd0);
    check("rst_palColor", 64'(bus.palColor), 64'd0);
    check("rst_palWriteData", 64'(bus.palWriteData), 64'd0);
    check("rst_rdData", 64'(bus.rdData), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_rdDataValid", 64'(bus.rdDataValid), 64'd0);
    check("rst_wrDataReady", 64'(bus.wrDataReady), 64'd0);
    check("rst_cmdReady", 64'(bus.cmdReady), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmdReady", 64'(bus.cmdReady), 64'd1);

    // Table-driven commands.
    preset.push_back(48'h1111_2222_3333);
    preset.push_back(48'hAAAA_BBBB_CCCC);
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].rd, vecs[i].layer, vecs[i].start, vecs[i].count,
              vecs[i].fmode, vecs[i].rmode, nwr, nrd, fc, lc);
      check("tbl_nwr", 64'(nwr), 64'(vecs[i].exp_nwr));
      check("tbl_nrd", 64'(nrd), 64'(vecs[i].exp_nrd));
      if (vecs[i].exp_nwr > 0) begin
        check("tbl_first_color", 64'(fc), 64'(vecs[i].exp_first));
        check("tbl_last_color", 64'(lc), 64'(vecs[i].exp_last));
      end
    end

    // Readback with latency and a 5-cycle host stall.
    pal_mem[7][9][0] = 16'h0102; pal_mem[7][9][1] = 16'h0304; pal_mem[7][9][2] = 16'h0506;
    ref_pal[7][9][0] = 16'h0102; ref_pal[7][9][1] = 16'h0304; ref_pal[7][9][2] = 16'h0506;
    rd_mode = 2;
    bus.rdDataReady = 1'b0;
    base = done_cnt;
    send_cmd(1'b1, 5'd7, 5'd9, 5'd1);
    @(negedge clk);
    check("rb_busy", 64'(bus.busy), 64'd1);
    k = 0;
    while (!bus.rdDataValid && k < 40) begin @(negedge clk); k++; end
    check("rb_latency", 64'(k), 64'd9);
    check("rb_data", 64'(bus.rdData), 64'h0102_0304_0506);
    hv = bus.rdData;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rb_valid_held", 64'(bus.rdDataValid), 64'd1);
      check("rb_data_held", 64'(bus.rdData), 64'(hv));
    end
    check("rb_no_early_done", 64'(done_cnt - base), 64'd0);
    bus.rdDataReady = 1'b1;
    @(negedge clk);
    check("rb_done", 64'(bus.done), 64'd1);
    check("rb_valid_drop", 64'(bus.rdDataValid), 64'd0);
    @(negedge clk);
    check("rb_done_once", 64'(bus.done), 64'd0);
    rd_mode = 0;

    // No-op followed immediately by another command.
    wr_log.delete();
    send_cmd(1'b0, 5'd4, 5'd4, 5'd0);
    @(negedge clk);
    check("noop_done_pulse", 64'(bus.done), 64'd1);
    check("noop_busy", 64'(bus.busy), 64'd0);
    check("noop_ready_next", 64'(bus.cmdReady), 64'd1);
    bus.cmdValid = 1'b1; bus.cmdRead = 1'b0; bus.cmdCount = 5'd0;
    @(posedge clk); #1; bus.cmdValid = 1'b0;
    @(negedge clk);
    check("noop2_done_pulse", 64'(bus.done), 64'd1);
    @(negedge clk);
    check("noop_done_clear", 64'(bus.done), 64'd0);
    check("noop_no_writes", 64'(wr_log.size()), 64'd0);

    // Reset in the middle of a load (during the G write).
    w1 = {16'($urandom), 16'($urandom), 16'($urandom)};
    w2 = {16'($urandom), 16'($urandom), 16'($urandom)};
    feed_mode = 0;
    feed_q.push_back(w1); feed_q.push_back(w2);
    send_cmd(1'b0, 5'd20, 5'd4, 5'd2);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (bus.palWriteEn && bus.palRGB == 2'b01) found = 1;
    end
    check("rst_reach_wr_g", 64'(found), 64'd1);
    base = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("abort_palWriteEn", 64'(bus.palWriteEn), 64'd0);
    check("abort_palRGB", 64'(bus.palRGB), 64'd3);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_palWriteData", 64'(bus.palWriteData), 64'd0);
    feed_q.delete();
    wr_log.delete();
    ref_pal[20][4][0] = w1[47:32];
    ref_pal[20][4][1] = w1[31:16];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cmdReady", 64'(bus.cmdReady), 64'd1);
    repeat (3) @(negedge clk);
    check("abort_no_writes", 64'(wr_log.size()), 64'd0);
    check("abort_no_done", 64'(done_cnt - base), 64'd0);

    // Random commands with random host stalls on both streams.
    for (int t = 0; t < 25; t++) begin
      logic [4:0] cnt;
      cnt = (t == 10) ? 5'd31 : 5'($urandom_range(0, 5));
      run_cmd(1'($urandom), 5'($urandom), 5'($urandom), cnt, 2, 1, nwr, nrd, fc, lc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
